// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable video sync/timing generator with a shadow-register config handshake.
// Define VIDEO_TIMING_FRAMECNT_EN to add the 16-bit frame_cnt output.
module video_timing_gen #(
  parameter int CW          = 11,
  parameter int DEF_HACTIVE = 640,
  parameter int DEF_HSSTART = 656,
  parameter int DEF_HSEND   = 752,
  parameter int DEF_HTOTAL  = 800,
  parameter int DEF_VACTIVE = 480,
  parameter int DEF_VSSTART = 490,
  parameter int DEF_VSEND   = 492,
  parameter int DEF_VTOTAL  = 525,
  parameter bit DEF_HPOL    = 1'b0,
  parameter bit DEF_VPOL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [CW-1:0] cfg_hactive,
  input  logic [CW-1:0] cfg_hsstart,
  input  logic [CW-1:0] cfg_hsend,
  input  logic [CW-1:0] cfg_htotal,
  input  logic [CW-1:0] cfg_vactive,
  input  logic [CW-1:0] cfg_vsstart,
  input  logic [CW-1:0] cfg_vsend,
  input  logic [CW-1:0] cfg_vtotal,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  input  logic          cfg_load,
  output logic          cfg_busy,
  output logic          cfg_ack,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          hblank,
  output logic          vblank,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          line_start,
  output logic          frame_start
`ifdef VIDEO_TIMING_FRAMECNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  typedef struct packed {
    logic [CW-1:0] hactive;
    logic [CW-1:0] hsstart;
    logic [CW-1:0] hsend;
    logic [CW-1:0] htotal;
    logic [CW-1:0] vactive;
    logic [CW-1:0] vsstart;
    logic [CW-1:0] vsend;
    logic [CW-1:0] vtotal;
    logic          hpol;
    logic          vpol;
  } timing_t;

  localparam timing_t DEF_TIMING = '{
    hactive: CW'(DEF_HACTIVE), hsstart: CW'(DEF_HSSTART),
    hsend:   CW'(DEF_HSEND),   htotal:  CW'(DEF_HTOTAL),
    vactive: CW'(DEF_VACTIVE), vsstart: CW'(DEF_VSSTART),
    vsend:   CW'(DEF_VSEND),   vtotal:  CW'(DEF_VTOTAL),
    hpol:    DEF_HPOL,         vpol:    DEF_VPOL
  };

  timing_t       act_t;
  timing_t       pend_t;
  timing_t       cfg_t;
  logic          busy_q;
  logic          ack_q;
  logic [CW-1:0] h_q;
  logic [CW-1:0] v_q;
  logic          h_wrap;
  logic          v_wrap;
  logic          apply;
  logic          h_act;
  logic          v_act;
  logic          hs_on;
  logic          vs_on;

  assign cfg_t = '{
    hactive: cfg_hactive, hsstart: cfg_hsstart, hsend: cfg_hsend, htotal: cfg_htotal,
    vactive: cfg_vactive, vsstart: cfg_vsstart, vsend: cfg_vsend, vtotal: cfg_vtotal,
    hpol:    cfg_hpol,    vpol:    cfg_vpol
  };

  // >= rather than == lets a counter beyond a newly shrunk total recover in one step
  assign h_wrap = (h_q >= act_t.htotal - CW'(1));
  assign v_wrap = (v_q >= act_t.vtotal - CW'(1));
  assign apply  = busy_q && (!enable || (h_wrap && v_wrap));

  assign h_act = (h_q < act_t.hactive);
  assign v_act = (v_q < act_t.vactive);
  assign hs_on = (h_q >= act_t.hsstart) && (h_q < act_t.hsend);
  assign vs_on = (v_q >= act_t.vsstart) && (v_q < act_t.vsend);

  assign cfg_busy = busy_q;
  assign cfg_ack  = ack_q;

  // A load landing on the apply cycle stays pending: apply copies the old pending set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_t  <= DEF_TIMING;
      pend_t <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= apply;
      if (apply) begin
        act_t <= pend_t;
      end
      if (cfg_load) begin
        pend_t <= cfg_t;
        busy_q <= 1'b1;
      end else if (apply) begin
        busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!enable) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_wrap) begin
      h_q <= '0;
      v_q <= v_wrap ? '0 : v_q + CW'(1);
    end else begin
      h_q <= h_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      vc          <= '0;
      de          <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hs          <= ~DEF_HPOL;
      vs          <= ~DEF_VPOL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      hc          <= '0;
      vc          <= '0;
      de          <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hs          <= ~act_t.hpol;
      vs          <= ~act_t.vpol;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= h_q;
      vc          <= v_q;
      de          <= h_act && v_act;
      hblank      <= !h_act;
      vblank      <= !v_act;
      hs          <= hs_on ? act_t.hpol : ~act_t.hpol;
      vs          <= vs_on ? act_t.vpol : ~act_t.vpol;
      line_start  <= (h_q == '0);
      frame_start <= (h_q == '0) && (v_q == '0);
    end
  end

`ifdef VIDEO_TIMING_FRAMECNT_EN
  logic wrap_d;

  // Delayed by one cycle so the count steps together with the registered frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_d    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wrap_d <= enable && h_wrap && v_wrap;
      if (enable && wrap_d) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, runtime-reprogrammable successor to the fixed-mode sync generator.
- Produces HS/VS, display enable, separate H/V blanking, pixel/line coordinates and line/frame start strobes from a single pixel clock.
- Timing is loaded through a shadow-register handshake and takes effect only at a frame boundary, so mode changes never produce a torn frame.
- Sits between the pixel-clock PLL and the pixel pipeline / TMDS or VGA output stage.

Parameters:
- CW, 11, coordinate/counter width in bits (all timing values and hc/vc).
- DEF_HACTIVE, 640, reset value of horizontal active pixels.
- DEF_HSSTART, 656, reset value of first HS pixel (end of front porch).
- DEF_HSEND, 752, reset value of first pixel after HS.
- DEF_HTOTAL, 800, reset value of pixels per line.
- DEF_VACTIVE, 480, reset value of active lines.
- DEF_VSSTART, 490, reset value of first VS line.
- DEF_VSEND, 492, reset value of first line after VS.
- DEF_VTOTAL, 525, reset value of lines per frame.
- DEF_HPOL, 0, reset HS polarity (0 = negative, 1 = positive).
- DEF_VPOL, 0, reset VS polarity.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run counters; low holds the generator idle
- cfg_hactive, cfg_hsstart, cfg_hsend, cfg_htotal  in  CW each  new horizontal timing
- cfg_vactive, cfg_vsstart, cfg_vsend, cfg_vtotal  in  CW each  new vertical timing
- cfg_hpol, cfg_vpol  in  1 each  new sync polarities
- cfg_load  in  1  one-cycle strobe: capture cfg_* into the pending set
- cfg_busy  out  1  pending set not yet applied
- cfg_ack  out  1  one-cycle pulse: pending set became active
- hs, vs  out  1 each  syncs, polarity applied
- de  out  1  active video
- hblank, vblank  out  1 each  high outside the horizontal / vertical active region
- hc, vc  out  CW each  coordinates aligned with the sync and enable outputs
- line_start  out  1  high when hc==0
- frame_start  out  1  high when hc==0 and vc==0

Behaviour:
- Reset (async, rst_n low): active set = DEF_*; pending cleared; internal counters = 0. Outputs: hc=0, vc=0, de=0, hblank=0, vblank=0, line_start=0, frame_start=0, cfg_busy=0, cfg_ack=0; hs=~DEF_HPOL, vs=~DEF_VPOL (inactive).
- Counters: h increments each clk while enable is high. When h >= active htotal-1 (>= so a smaller value self-recovers), h wraps to 0. On that wrap, v increments, or wraps to 0 when v >= vtotal-1.
- Outputs: all are registered from the counter state, one clk latency. hc/vc are the registered copies, so every output refers to the same pixel.
  - de = (h < hactive) && (v < vactive).
  - hblank = !(h < hactive); vblank = !(v < vactive).
  - hs active (= hpol) when hsstart <= h < hsend, else ~hpol; vs likewise on v with vpol.
- enable low: counters forced to 0 and held; outputs show inactive syncs, de=0, strobes 0. After enable rises, the first output cycle is hc=0, vc=0, frame_start=1.
- Config handshake:
  - cfg_load captures all cfg_* into pending and sets cfg_busy the next cycle.
  - A new cfg_load while busy overwrites pending (last writer wins), with no extra ack.
  - Pending is copied to active on the last pixel of a frame (h==htotal-1 && v==vtotal-1), or on the next cycle if enable is low.
  - The cycle after the copy: cfg_busy=0, cfg_ack=1 for exactly one cycle, and the counters run from 0,0 under the new timing.
  - cfg_load coinciding with the apply cycle: the apply uses the already-pending data; the newly loaded data stays pending (busy stays 1, ack still pulses).
- Values are not validated. The integrator guarantees active < sstart <= send <= total, and total >= 2.
- Reset mid-frame: immediate return to reset state; any pending config is discarded.

Optional Feature:
- Macro VIDEO_TIMING_FRAMECNT_EN.
- Defined: adds output frame_cnt (16 bits). It resets to 0, increments on every frame wrap (v wrap), wraps modulo 2^16, and holds while enable is low. It is registered so that it changes in the same cycle as frame_start goes high.
- Undefined: the port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset defaults, enable=1, run 2 frames -> hs low exactly for hc 656..751; vs low for vc 490..491; de count per frame 307200; frame period 420000 clk; frame_start once per frame.
- Latency/alignment -> frame_start high with hc=0, vc=0 and de=1 on the same output cycle; first output after enable rises is hc=0/vc=0.
- Load 800x600 (h 800/840/968/1056, v 600/601/605/628, pol 1/1) mid-frame -> cfg_busy=1 until end of frame; cfg_ack one pulse; next frame period 663168 clk; hs high for hc 840..967.
- Two cfg_load in one frame (640x480 then 1024x768 timing) -> single ack; the applied frame uses 1024x768 values.
- enable=0 with a pending load -> applied next cycle, ack pulse; outputs idle (de=0, syncs inactive) until enable rises.
- rst_n low at hc=300, vc=200 with pending config -> outputs return to reset values immediately (async); after release the default 640x480 timing runs; frame_cnt=0 when the macro is defined.
